// File: rtl/ram_burst_model.sv
// ram_burst_model
// -----------------------------------------------------------------------------
// Behavioural burst RAM used as the memory endpoint underneath the AXI/DDR3
// controller benches. Separate write and read channels; each burst starts at
// a sampled start address and the word address auto-increments every beat.
// Read data returns through an RD_LAT-deep pipeline with an rd_valid strobe.
//
// Optional feature macro: RAM_BYTE_STRB_EN
//   defined   -> wr_strb port exists, only strobed bytes are written
//   undefined -> no wr_strb port, every write beat writes the full word
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (memory contents are preserved)
//   wr_en     write burst active, one beat per cycle while high
//   wr_addr   write burst start address (sampled on the first beat only)
//   wr_data   write beat data
//   wr_strb   byte enables (RAM_BYTE_STRB_EN builds only)
//   rd_en     read burst active, one beat per cycle while high
//   rd_addr   read burst start address (sampled on the first beat only)
//   rd_data   read data, 0 whenever rd_valid is low
//   rd_valid  rd_data carries a beat this cycle
//   wr_beats  beats in the current or last write burst (saturating)
//   rd_beats  beats in the current or last read burst (saturating)
//
// Addresses are used modulo 2^DEPTH_LOG2; ADDR_W is expected to exceed
// DEPTH_LOG2.
// -----------------------------------------------------------------------------
module ram_burst_model #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 30,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
`ifdef RAM_BYTE_STRB_EN
  input  logic [DATA_W/8-1:0] wr_strb,
`endif
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [15:0]         wr_beats,
  output logic [15:0]         rd_beats
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Beat counter update: 1 on a burst start, +1 per continuation beat,
  // saturating, and held once the burst has ended.
  function automatic logic [15:0] next_beats(input logic start,
                                             input logic en,
                                             input logic [15:0] cnt);
    logic [15:0] nxt;
    if (start) begin
      nxt = 16'd1;
    end else if (en && (cnt != 16'hFFFF)) begin
      nxt = cnt + 16'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

`ifdef RAM_BYTE_STRB_EN
  // Byte-lane merge: strobed lanes take the new data, others keep the old.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [NBYTES-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < NBYTES; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  // Write channel state
  logic                  wr_en_prev_q, wr_en_prev_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]           wr_beats_q, wr_beats_d;
  logic                  wr_start_s;
  logic [DEPTH_LOG2-1:0] wr_addr_s;
  logic [DATA_W-1:0]     wr_word_s;

  // Read channel state
  logic                  rd_en_prev_q, rd_en_prev_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]           rd_beats_q, rd_beats_d;
  logic                  rd_start_s;
  logic [DEPTH_LOG2-1:0] rd_addr_s;
  logic [DATA_W-1:0]     rd_data_pipe_q [RD_LAT];
  logic [DATA_W-1:0]     rd_data_pipe_d [RD_LAT];
  logic [RD_LAT-1:0]     rd_valid_pipe_q, rd_valid_pipe_d;

  // Address bits above the storage depth are intentionally ignored.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{wr_addr[ADDR_W-1:DEPTH_LOG2], rd_addr[ADDR_W-1:DEPTH_LOG2]};

  // Write channel: start detection, beat address, pointer and counter.
  always_comb begin
    wr_en_prev_d = wr_en;
    wr_start_s   = wr_en & ~wr_en_prev_q;
    if (wr_start_s) begin
      wr_addr_s = wr_addr[DEPTH_LOG2-1:0];
    end else begin
      wr_addr_s = wr_ptr_q;
    end
    if (wr_en) begin
      wr_ptr_d = wr_addr_s + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    wr_beats_d = next_beats(wr_start_s, wr_en, wr_beats_q);
`ifdef RAM_BYTE_STRB_EN
    wr_word_s = merge_bytes(mem[wr_addr_s], wr_data, wr_strb);
`else
    wr_word_s = wr_data;
`endif
  end

  // Read channel: start detection, beat address, pointer, counter and the
  // latency pipeline shift. Empty stages carry zero so rd_data is 0 when
  // not valid without any output gating.
  always_comb begin
    rd_en_prev_d = rd_en;
    rd_start_s   = rd_en & ~rd_en_prev_q;
    if (rd_start_s) begin
      rd_addr_s = rd_addr[DEPTH_LOG2-1:0];
    end else begin
      rd_addr_s = rd_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d          = rd_addr_s + PTR_ONE;
      rd_data_pipe_d[0] = mem[rd_addr_s];
    end else begin
      rd_ptr_d          = rd_ptr_q;
      rd_data_pipe_d[0] = {DATA_W{1'b0}};
    end
    rd_valid_pipe_d    = {RD_LAT{1'b0}};
    rd_valid_pipe_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_data_pipe_d[i]  = rd_data_pipe_q[i-1];
      rd_valid_pipe_d[i] = rd_valid_pipe_q[i-1];
    end
    rd_beats_d = next_beats(rd_start_s, rd_en, rd_beats_q);
  end

  // Channel state registers. Reset clears in-flight read beats at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_prev_q    <= 1'b0;
      wr_ptr_q        <= {DEPTH_LOG2{1'b0}};
      wr_beats_q      <= 16'd0;
      rd_en_prev_q    <= 1'b0;
      rd_ptr_q        <= {DEPTH_LOG2{1'b0}};
      rd_beats_q      <= 16'd0;
      rd_valid_pipe_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        rd_data_pipe_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_en_prev_q    <= wr_en_prev_d;
      wr_ptr_q        <= wr_ptr_d;
      wr_beats_q      <= wr_beats_d;
      rd_en_prev_q    <= rd_en_prev_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_beats_q      <= rd_beats_d;
      rd_valid_pipe_q <= rd_valid_pipe_d;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_data_pipe_q[i] <= rd_data_pipe_d[i];
      end
    end
  end

  // Storage array: no reset so contents survive rst_n. The read stage samples
  // the array before this update lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_s] <= wr_word_s;
    end
  end

  assign rd_data  = rd_data_pipe_q[RD_LAT-1];
  assign rd_valid = rd_valid_pipe_q[RD_LAT-1];
  assign wr_beats = wr_beats_q;
  assign rd_beats = rd_beats_q;

endmodule

// File: tb/tb_ram_burst_model.sv
// Self-checking bench for ram_burst_model (DEPTH_LOG2=4, RD_LAT=2).
// Table of per-cycle vectors for the main burst/wrap/restart cases, plus
// hand-written sequences for read-before-write, byte strobes and reset.
// Expected read data is pushed to a scoreboard queue with its due cycle when
// the read beat is driven and is popped by a negedge monitor.
module tb_ram_burst_model;

  localparam int DW  = 64;
  localparam int AW  = 30;
  localparam int DL  = 4;
  localparam int LAT = 2;

  localparam logic [63:0] D0 = 64'h0706050403020100;
  localparam logic [63:0] D1 = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] D2 = 64'h1716151413121110;
  localparam logic [63:0] D3 = 64'h1F1E1D1C1B1A1918;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    wr_strb;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [15:0]   wr_beats;
  logic [15:0]   rd_beats;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;

  typedef struct packed {
    logic [63:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_rd;
    logic [15:0]   exp_wb;
    logic [15:0]   exp_rb;
  } vec_t;
  vec_t tbl [28];

  ram_burst_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .RD_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef RAM_BYTE_STRB_EN
    .wr_strb (wr_strb),
`endif
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_beats(wr_beats),
    .rd_beats(rd_beats)
  );

`ifndef RAM_BYTE_STRB_EN
  wire unused_strb = ^wr_strb;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; a read beat queues its expected data.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [7:0] ws, input logic re, input logic [AW-1:0] ra,
                       input logic [DW-1:0] exp_rd);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_strb = ws;
    rd_en   = re;
    rd_addr = ra;
    if (re) sb.push_back('{exp_rd, cycle_cnt + LAT});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 8'hFF, 1'b0, '0, '0);
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, 8'hFF, tbl[i].re, tbl[i].ra, tbl[i].exp_rd);
      check($sformatf("wr_beats[%0d]", i), {48'd0, wr_beats}, {48'd0, tbl[i].exp_wb});
      check($sformatf("rd_beats[%0d]", i), {48'd0, rd_beats}, {48'd0, tbl[i].exp_rb});
    end
  endtask

  // Scoreboard monitor: every cycle rd_valid/rd_data must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() != 0 && sb[0].due == cycle_cnt) begin
        check("rd_valid_hi", {63'd0, rd_valid}, 64'd1);
        check("rd_data", rd_data, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("rd_valid_lo", {63'd0, rd_valid}, 64'd0);
        check("rd_data_zero", rd_data, 64'd0);
        if (sb.size() != 0 && sb[0].due < cycle_cnt) begin
          check("missed_beat", 64'd0, 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    // Test 1: 4-beat write/read at 7 (upper address bits set on write start)
    tbl[0]  = '{1'b1, 30'h1000_0007, D0, 1'b0, 30'd0, 64'd0, 16'd1, 16'd0};
    tbl[1]  = '{1'b1, 30'd0, D1, 1'b0, 30'd0, 64'd0, 16'd2, 16'd0};
    tbl[2]  = '{1'b1, 30'd0, D2, 1'b0, 30'd0, 64'd0, 16'd3, 16'd0};
    tbl[3]  = '{1'b1, 30'd0, D3, 1'b0, 30'd0, 64'd0, 16'd4, 16'd0};
    tbl[4]  = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd4, 16'd0};
    tbl[5]  = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd7, D0, 16'd4, 16'd1};
    tbl[6]  = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, D1, 16'd4, 16'd2};
    tbl[7]  = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, D2, 16'd4, 16'd3};
    tbl[8]  = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, D3, 16'd4, 16'd4};
    tbl[9]  = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd4, 16'd4};
    // Test 2: wrap at 16 words, write 14,15,0,1 then read 0 and 14
    tbl[10] = '{1'b1, 30'h0100_000E, 64'd1, 1'b0, 30'd0, 64'd0, 16'd1, 16'd4};
    tbl[11] = '{1'b1, 30'd0, 64'd2, 1'b0, 30'd0, 64'd0, 16'd2, 16'd4};
    tbl[12] = '{1'b1, 30'd0, 64'd3, 1'b0, 30'd0, 64'd0, 16'd3, 16'd4};
    tbl[13] = '{1'b1, 30'd0, 64'd4, 1'b0, 30'd0, 64'd0, 16'd4, 16'd4};
    tbl[14] = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd4, 16'd4};
    tbl[15] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'h2000_0000, 64'd3, 16'd4, 16'd1};
    tbl[16] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, 64'd4, 16'd4, 16'd2};
    tbl[17] = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd4, 16'd2};
    tbl[18] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd14, 64'd1, 16'd4, 16'd1};
    tbl[19] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, 64'd2, 16'd4, 16'd2};
    tbl[20] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, 64'd3, 16'd4, 16'd3};
    tbl[21] = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd4, 16'd3};
    // Test 6: restart, words 0,1 then 8,9 (counters cleared by earlier reset)
    tbl[22] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, 64'd3, 16'd0, 16'd1};
    tbl[23] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, 64'd4, 16'd0, 16'd2};
    tbl[24] = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd0, 16'd2};
    tbl[25] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd8, D1, 16'd0, 16'd1};
    tbl[26] = '{1'b0, 30'd0, 64'd0, 1'b1, 30'd0, D2, 16'd0, 16'd2};
    tbl[27] = '{1'b0, 30'd0, 64'd0, 1'b0, 30'd0, 64'd0, 16'd0, 16'd2};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = 8'hFF;
    rd_en = 1'b0; rd_addr = '0;
    #12;
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_wr_beats", {48'd0, wr_beats}, 64'd0);
    check("rst_rd_beats", {48'd0, rd_beats}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_vectors(0, 21);

    // Test 3: read-before-write on addr 5, then write-then-read on addr 6
    drive(1'b1, 30'd5, 64'hAA, 8'hFF, 1'b0, 30'd0, 64'd0);
    idle();
    drive(1'b1, 30'd5, 64'hBB, 8'hFF, 1'b1, 30'd5, 64'hAA);
    idle();
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd5, 64'hBB);
    idle();
    drive(1'b1, 30'd6, 64'hCC, 8'hFF, 1'b0, 30'd0, 64'd0);
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd6, 64'hCC);
    idle();
    check("wr_beats_single", {48'd0, wr_beats}, 64'd1);

`ifdef RAM_BYTE_STRB_EN
    // Test 4: low-half strobe leaves upper bytes untouched
    drive(1'b1, 30'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 30'd0, 64'd0);
    idle();
    drive(1'b1, 30'd3, 64'h0, 8'h0F, 1'b0, 30'd0, 64'd0);
    idle();
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd3, 64'hFFFF_FFFF_0000_0000);
    idle();
`endif

    // Test 5: reset in the middle of a 3-beat read
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd7, D0);
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd0, D1);
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd0, D2);
    check("pre_rst_valid", {63'd0, rd_valid}, 64'd1);
    check("pre_rst_data", rd_data, D1);
    rd_en = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", {63'd0, rd_valid}, 64'd0);
    check("mid_rst_data", rd_data, 64'd0);
    check("mid_rst_rd_beats", {48'd0, rd_beats}, 64'd0);
    check("mid_rst_wr_beats", {48'd0, wr_beats}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) idle();
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd7, D0);
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd0, D1);
    drive(1'b0, 30'd0, 64'd0, 8'hFF, 1'b1, 30'd0, D2);
    idle();
    check("post_rst_rd_beats", {48'd0, rd_beats}, 64'd3);

    run_vectors(22, 27);

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
    idle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_model.md
Name: ram_burst_model

Overview:
Parametrised behavioural burst RAM that replaces the fixed 64-bit shared-bus RAM model used in the DDR3 controller simulations. Has separate write and read channels, so the bus is no longer tri-state. Each burst starts from a single start address, and the address auto-increments every beat. Provides configurable read latency, an rd_valid strobe and per-burst beat counters. Sits below the AXI/DDR3 controller benches as the memory endpoint.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8.
ADDR_W, 30, width of the wr_addr/rd_addr ports (word address).
DEPTH_LOG2, 10, log2 of the number of words stored; addresses are used modulo 2^DEPTH_LOG2.
RD_LAT, 2, cycles from a read beat being accepted to its data appearing; legal range 1..8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write burst active; one beat per cycle while high
wr_addr  in  ADDR_W  burst start address, sampled on the first cycle of a write burst
wr_data  in  DATA_W  write beat data
wr_strb  in  DATA_W/8  byte enables; present only with RAM_BYTE_STRB_EN
rd_en  in  1  read burst active; one beat per cycle while high
rd_addr  in  ADDR_W  burst start address, sampled on the first cycle of a read burst
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid this cycle
wr_beats  out  16  beats in the current or last write burst
rd_beats  out  16  beats in the current or last read burst

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, the latency pipeline, rd_data, rd_valid, wr_beats and rd_beats all go to 0.
  - Burst-start detectors are cleared.
  - Memory contents are preserved (not cleared).
- Burst start:
  - A cycle with wr_en=1 whose previous cycle had wr_en=0 (or the first cycle after reset) is a write start.
  - On a write start, the beat address is wr_addr[DEPTH_LOG2-1:0] and wr_ptr is loaded with that address + 1.
  - Read bursts work the same way using rd_en and rd_addr.
- Write beat, each cycle with wr_en=1:
  - mem[addr] <= wr_data.
  - On a continuation beat, addr = wr_ptr and wr_ptr is incremented.
  - The pointer wraps from 2^DEPTH_LOG2-1 to 0.
- Read beat, each cycle with rd_en=1:
  - mem[addr] is sampled into stage 1 of an RD_LAT-deep pipeline.
  - rd_valid/rd_data appear exactly RD_LAT cycles after the beat's rising edge.
  - Pointer and wrap rules are the same as for writes.
- When the read pipeline output is not valid, rd_data holds 0 and rd_valid=0.
- Simultaneous write and read to the same address in the same cycle: the read returns the OLD contents (read-before-write).
  - A read one cycle later returns the new data.
- Beat counters:
  - The counter is set to 1 on a burst start and incremented on each continuation beat.
  - It saturates at 16'hFFFF.
  - It holds its value after the burst ends until the next start.
- Ending a burst: deasserting en ends the burst with no further action.
  - Read beats already in flight still complete.
  - Re-asserting en starts a new burst at the new start address.
- Reset mid-burst: in-flight read beats are discarded and rd_valid is 0 immediately.
- Width rules:
  - Upper address bits above DEPTH_LOG2 are ignored.
  - Pointers are DEPTH_LOG2 bits wide and wrap naturally.

Optional Feature:
RAM_BYTE_STRB_EN:
- Defined: the wr_strb port exists, and byte k of mem[addr] is written only when wr_strb[k]=1. Bytes with a 0 strobe keep their previous value.
- Undefined: there is no wr_strb port, and every write beat writes the full word.

Test Plan:
1. Reset, then a 4-beat write from wr_addr=7 with data 64'h0706050403020100, incrementing each byte by 8 per beat, then a 4-beat read from rd_addr=7 -> rd_valid high for 4 cycles starting RD_LAT=2 cycles after the first read beat. rd_data = 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918. wr_beats=rd_beats=4.
2. Wrap with DEPTH_LOG2=4: 4-beat write from addr 14 with data 1..4 -> words 14, 15, 0, 1 hold 1, 2, 3, 4. A read from addr 0 returns 3, 4.
3. Same-cycle read and write at addr 5 (old value 32'hAA, new value 32'hBB) -> read returns 32'hAA; a read of addr 5 on the next cycle returns 32'hBB.
4. RAM_BYTE_STRB_EN defined: write 64'hFFFF_FFFF_FFFF_FFFF to addr 3, then 64'h0 with wr_strb=8'h0F -> a read of addr 3 returns 64'hFFFF_FFFF_0000_0000.
5. Issue a 3-beat read, assert rst_n=0 one cycle later -> rd_valid=0 and rd_data=0 immediately, no valid beats after release, and memory is unchanged on re-read.
6. Burst restart: rd_en high 2 cycles at addr 0, low 1 cycle, high 2 cycles at addr 8 -> data from words 0, 1, 8, 9, and rd_beats reads 2 after each burst.
